// File: rtl/change_return_sequencer_pkg.sv
// Shared constants and state encoding for the change-return sequencer.
package change_return_sequencer_pkg;

    localparam int unsigned kNumCoins    = 3;
    localparam int unsigned kTotalBits   = 31;
    localparam int unsigned kWaitTime    = 100;

    localparam int unsigned kCoinVal100  = 100;
    localparam int unsigned kCoinVal500  = 500;
    localparam int unsigned kCoinVal1000 = 1000;

    typedef enum logic [1:0] {
        kRetIdle     = 2'd0,
        kRetDispense = 2'd1,
        kRetSettle   = 2'd2
    } ret_state_e;

endpackage

// File: rtl/change_coin_select.sv
// Picks the largest returnable coin for a given balance (combinational).
module change_coin_select
    import change_return_sequencer_pkg::*;
#(
    parameter int unsigned NUM_COINS = kNumCoins,
    parameter int unsigned TOTAL_W   = kTotalBits
) (
    input  logic [TOTAL_W-1:0]   i_total,
    output logic [NUM_COINS-1:0] o_coin,
    output logic [TOTAL_W-1:0]   o_value,
    output logic                 o_has_coin
);

    always_comb begin
        o_coin     = '0;
        o_value    = '0;
        o_has_coin = 1'b0;
        if (i_total >= TOTAL_W'(kCoinVal1000)) begin
            o_coin[2]  = 1'b1;
            o_value    = TOTAL_W'(kCoinVal1000);
            o_has_coin = 1'b1;
        end else if (i_total >= TOTAL_W'(kCoinVal500)) begin
            o_coin[1]  = 1'b1;
            o_value    = TOTAL_W'(kCoinVal500);
            o_has_coin = 1'b1;
        end else if (i_total >= TOTAL_W'(kCoinVal100)) begin
            o_coin[0]  = 1'b1;
            o_value    = TOTAL_W'(kCoinVal100);
            o_has_coin = 1'b1;
        end
    end

endmodule

// File: rtl/change_return_sequencer.sv
// Inactivity timer plus coin-by-coin change payout over a valid/ready hopper interface.
module change_return_sequencer
    import change_return_sequencer_pkg::*;
#(
    parameter int unsigned NUM_COINS   = kNumCoins,
    parameter int unsigned TOTAL_W     = kTotalBits,
    parameter int unsigned WAIT_CYCLES = kWaitTime
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_activity,
    input  logic                 i_trigger_return,
    input  logic [TOTAL_W-1:0]   i_current_total,
    input  logic                 i_coin_ready,
    output logic                 o_coin_valid,
    output logic [NUM_COINS-1:0] o_return_coin,
    output logic                 o_deduct_en,
    output logic [TOTAL_W-1:0]   o_deduct_value,
    output logic                 o_busy,
    output logic [31:0]          o_wait_time
);

    localparam logic [31:0] kWaitMax = 32'(WAIT_CYCLES);

    ret_state_e           r_state, w_state_d;
    logic [NUM_COINS-1:0] r_coin, w_coin_d;
    logic [TOTAL_W-1:0]   r_coin_val, w_coin_val_d;
    logic [31:0]          r_wait, w_wait_d;

    logic [TOTAL_W-1:0]   w_eval_total;
    logic [NUM_COINS-1:0] w_sel_coin;
    logic [TOTAL_W-1:0]   w_sel_value;
    logic                 w_sel_has;

    // In SETTLE the balance register has not yet absorbed the deduct, so look ahead at the
    // post-deduct balance; this keeps the payout at one coin every two cycles.
    assign w_eval_total = (r_state == kRetSettle) ? (i_current_total - r_coin_val)
                                                  : i_current_total;

    change_coin_select #(
        .NUM_COINS (NUM_COINS),
        .TOTAL_W   (TOTAL_W)
    ) u_coin_select (
        .i_total    (w_eval_total),
        .o_coin     (w_sel_coin),
        .o_value    (w_sel_value),
        .o_has_coin (w_sel_has)
    );

    always_comb begin
        w_state_d    = r_state;
        w_coin_d     = r_coin;
        w_coin_val_d = r_coin_val;
        w_wait_d     = r_wait;
        case (r_state)
            kRetIdle: begin
                if (i_activity || !w_sel_has) begin
                    w_wait_d = kWaitMax;
                end else if (i_trigger_return || (r_wait == 32'd0)) begin
                    w_coin_d     = w_sel_coin;
                    w_coin_val_d = w_sel_value;
                    w_state_d    = kRetDispense;
                end else begin
                    w_wait_d = r_wait - 32'd1;
                end
            end
            kRetDispense: begin
                if (i_coin_ready) begin
                    w_state_d = kRetSettle;
                end
            end
            kRetSettle: begin
                if (w_sel_has) begin
                    w_coin_d     = w_sel_coin;
                    w_coin_val_d = w_sel_value;
                    w_state_d    = kRetDispense;
                end else begin
                    w_wait_d  = kWaitMax;
                    w_state_d = kRetIdle;
                end
            end
            default: begin
                w_wait_d  = kWaitMax;
                w_state_d = kRetIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= kRetIdle;
            r_coin     <= '0;
            r_coin_val <= '0;
            r_wait     <= kWaitMax;
        end else begin
            r_state    <= w_state_d;
            r_coin     <= w_coin_d;
            r_coin_val <= w_coin_val_d;
            r_wait     <= w_wait_d;
        end
    end

    assign o_coin_valid   = (r_state == kRetDispense);
    assign o_return_coin  = o_coin_valid ? r_coin : '0;
    assign o_deduct_en    = (r_state == kRetSettle);
    assign o_deduct_value = o_deduct_en ? r_coin_val : '0;
    assign o_busy         = (r_state != kRetIdle);
    assign o_wait_time    = r_wait;

endmodule

// File: tb/tb_change_return_sequencer.sv
// Scenario bench for change_return_sequencer with a coin/deduct scoreboard and a balance model.
module tb_change_return_sequencer;

    localparam int unsigned WAIT = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_activity;
    logic        i_trigger_return;
    logic [30:0] i_current_total;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_return_coin;
    logic        o_deduct_en;
    logic [30:0] o_deduct_value;
    logic        o_busy;
    logic [31:0] o_wait_time;

    int checks = 0;
    int errors = 0;

    logic [2:0]  exp_coin_q[$];
    logic [30:0] exp_val_q[$];
    logic        pend_en = 1'b0;
    logic [30:0] pend_val = '0;

    always #5 clk = ~clk;

    change_return_sequencer #(
        .NUM_COINS   (3),
        .TOTAL_W     (31),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_activity       (i_activity),
        .i_trigger_return (i_trigger_return),
        .i_current_total  (i_current_total),
        .i_coin_ready     (i_coin_ready),
        .o_coin_valid     (o_coin_valid),
        .o_return_coin    (o_return_coin),
        .o_deduct_en      (o_deduct_en),
        .o_deduct_value   (o_deduct_value),
        .o_busy           (o_busy),
        .o_wait_time      (o_wait_time)
    );

    // Greedy change model: what the hopper should receive for a given balance.
    task automatic push_expected(input int unsigned total);
        int unsigned t = total;
        while (t >= 100) begin
            if (t >= 1000) begin
                exp_coin_q.push_back(3'b100); exp_val_q.push_back(31'd1000); t -= 1000;
            end else if (t >= 500) begin
                exp_coin_q.push_back(3'b010); exp_val_q.push_back(31'd500);  t -= 500;
            end else begin
                exp_coin_q.push_back(3'b001); exp_val_q.push_back(31'd100);  t -= 100;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_activity = 1'b0; i_trigger_return = 1'b0; i_coin_ready = 1'b0;
        i_current_total = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_wait_time !== 32'(WAIT) || o_coin_valid !== 1'b0 || o_busy !== 1'b0
            || o_deduct_en !== 1'b0 || o_return_coin !== 3'b000 || o_deduct_value !== '0) begin
            errors++;
            $display("FAIL reset_state wait=%0d valid=%b busy=%b ded=%b coin=%b val=%0d want wait=%0d rest 0",
                     o_wait_time, o_coin_valid, o_busy, o_deduct_en, o_return_coin,
                     o_deduct_value, WAIT);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_wait_time !== 32'(WAIT)) begin
            errors++;
            $display("FAIL zero_total_timer got %0d want %0d", o_wait_time, WAIT);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int budget = 0;
        i_coin_ready = 1'b1;
        i_current_total = 31'd1600;
        while (!o_coin_valid && n < 300) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n != int'(WAIT) + 1) begin
            errors++;
            $display("FAIL timeout_latency got %0d edges want %0d", n, WAIT + 1);
        end
        push_expected(1600);
        while ((exp_coin_q.size() != 0 || o_busy) && budget < 200) begin
            if (o_deduct_en) begin
                checks++;
                if (exp_val_q.size() == 0 || o_deduct_value !== exp_val_q[0]) begin
                    errors++;
                    $display("FAIL timeout_deduct got %0d want %0d", o_deduct_value,
                             exp_val_q.size() != 0 ? exp_val_q[0] : 31'd0);
                end
                if (exp_val_q.size() != 0) void'(exp_val_q.pop_front());
                pend_en = 1'b1; pend_val = o_deduct_value;
            end
            if (o_coin_valid && i_coin_ready) begin
                checks++;
                if (exp_coin_q.size() == 0 || o_return_coin !== exp_coin_q[0]) begin
                    errors++;
                    $display("FAIL timeout_coin got %b want %b", o_return_coin,
                             exp_coin_q.size() != 0 ? exp_coin_q[0] : 3'b000);
                end
                if (exp_coin_q.size() != 0) void'(exp_coin_q.pop_front());
            end
            @(negedge clk); budget++;
            if (pend_en) begin i_current_total = i_current_total - pend_val; pend_en = 1'b0; end
        end
        checks++;
        if (budget >= 200 || exp_val_q.size() != 0 || i_current_total !== 31'd0
            || o_wait_time !== 32'(WAIT)) begin
            errors++;
            $display("FAIL timeout_end total=%0d wait=%0d left=%0d budget=%0d want total=0 wait=%0d left=0",
                     i_current_total, o_wait_time, exp_val_q.size(), budget, WAIT);
        end
    endtask

    task automatic test_button();
        int budget = 0;
        i_coin_ready = 1'b1;
        i_current_total = 31'd700;
        repeat (4) @(negedge clk);
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        checks++;
        if (o_coin_valid !== 1'b1 || o_return_coin !== 3'b010) begin
            errors++;
            $display("FAIL button_latency valid=%b coin=%b want valid=1 coin=010",
                     o_coin_valid, o_return_coin);
        end
        push_expected(700);
        while ((exp_coin_q.size() != 0 || o_busy) && budget < 100) begin
            if (o_deduct_en) begin
                checks++;
                if (exp_val_q.size() == 0 || o_deduct_value !== exp_val_q[0]) begin
                    errors++;
                    $display("FAIL button_deduct got %0d want %0d", o_deduct_value,
                             exp_val_q.size() != 0 ? exp_val_q[0] : 31'd0);
                end
                if (exp_val_q.size() != 0) void'(exp_val_q.pop_front());
                pend_en = 1'b1; pend_val = o_deduct_value;
            end
            if (o_coin_valid && i_coin_ready) begin
                checks++;
                if (exp_coin_q.size() == 0 || o_return_coin !== exp_coin_q[0]) begin
                    errors++;
                    $display("FAIL button_coin got %b want %b", o_return_coin,
                             exp_coin_q.size() != 0 ? exp_coin_q[0] : 3'b000);
                end
                if (exp_coin_q.size() != 0) void'(exp_coin_q.pop_front());
            end
            @(negedge clk); budget++;
            if (pend_en) begin i_current_total = i_current_total - pend_val; pend_en = 1'b0; end
        end
        checks++;
        if (budget >= 100 || exp_val_q.size() != 0 || i_current_total !== 31'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL button_end total=%0d busy=%b left=%0d want total=0 busy=0 left=0",
                     i_current_total, o_busy, exp_val_q.size());
        end
    endtask

    task automatic test_backpressure();
        int budget = 0;
        i_coin_ready = 1'b0;
        i_current_total = 31'd1000;
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (o_coin_valid !== 1'b1 || o_return_coin !== 3'b100 || o_deduct_en !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d valid=%b coin=%b ded=%b want 1 100 0",
                         i, o_coin_valid, o_return_coin, o_deduct_en);
            end
            @(negedge clk);
        end
        push_expected(1000);
        i_coin_ready = 1'b1;
        while ((exp_coin_q.size() != 0 || o_busy) && budget < 50) begin
            if (o_deduct_en) begin
                checks++;
                if (exp_val_q.size() == 0 || o_deduct_value !== exp_val_q[0]) begin
                    errors++;
                    $display("FAIL backpressure_deduct got %0d want %0d", o_deduct_value,
                             exp_val_q.size() != 0 ? exp_val_q[0] : 31'd0);
                end
                if (exp_val_q.size() != 0) void'(exp_val_q.pop_front());
                pend_en = 1'b1; pend_val = o_deduct_value;
            end
            if (o_coin_valid && i_coin_ready) begin
                checks++;
                if (exp_coin_q.size() == 0 || o_return_coin !== exp_coin_q[0]) begin
                    errors++;
                    $display("FAIL backpressure_coin got %b want %b", o_return_coin,
                             exp_coin_q.size() != 0 ? exp_coin_q[0] : 3'b000);
                end
                if (exp_coin_q.size() != 0) void'(exp_coin_q.pop_front());
            end
            @(negedge clk); budget++;
            if (pend_en) begin i_current_total = i_current_total - pend_val; pend_en = 1'b0; end
        end
        checks++;
        if (budget >= 50 || exp_val_q.size() != 0 || i_current_total !== 31'd0) begin
            errors++;
            $display("FAIL backpressure_end total=%0d left=%0d want total=0 left=0",
                     i_current_total, exp_val_q.size());
        end
    endtask

    task automatic test_reset_mid_dispense();
        i_coin_ready = 1'b0;
        i_current_total = 31'd500;
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        checks++;
        if (o_coin_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup valid got %b want 1", o_coin_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (o_coin_valid !== 1'b0 || o_wait_time !== 32'(WAIT) || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async valid=%b wait=%0d busy=%b want 0 %0d 0",
                     o_coin_valid, o_wait_time, o_busy, WAIT);
        end
        i_coin_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_deduct_en !== 1'b0 || o_coin_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_deduct ded=%b valid=%b want 0 0", o_deduct_en, o_coin_valid);
        end
        i_current_total = '0;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_activity();
        int valids = 0;
        i_current_total = 31'd300;
        for (int i = 0; i < 300; i++) begin
            i_activity = (i % 50 == 0);
            @(negedge clk);
            if (o_coin_valid) valids++;
            if (i % 50 == 0) begin
                checks++;
                if (o_wait_time !== 32'(WAIT)) begin
                    errors++;
                    $display("FAIL activity_reload cyc=%0d got %0d want %0d", i, o_wait_time, WAIT);
                end
            end
        end
        i_activity = 1'b0;
        checks++;
        if (valids != 0) begin
            errors++;
            $display("FAIL activity_no_dispense got %0d valid cycles want 0", valids);
        end
        i_activity = 1'b1; i_trigger_return = 1'b1;
        @(negedge clk);
        i_activity = 1'b0; i_trigger_return = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_wait_time !== 32'(WAIT - 3)) begin
            errors++;
            $display("FAIL activity_beats_trigger valid=%b busy=%b wait=%0d want 0 0 %0d",
                     o_coin_valid, o_busy, o_wait_time, WAIT - 3);
        end
        i_current_total = '0;
        @(negedge clk);
    endtask

    task automatic test_small_balance();
        i_current_total = 31'd60;
        i_trigger_return = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_wait_time !== 32'(WAIT)) begin
                errors++;
                $display("FAIL small_balance cyc=%0d valid=%b busy=%b wait=%0d want 0 0 %0d",
                         i, o_coin_valid, o_busy, o_wait_time, WAIT);
            end
        end
        i_trigger_return = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_button();
        test_backpressure();
        test_reset_mid_dispense();
        test_activity();
        test_small_balance();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
